// File: rtl/lsu_mem_adapter.sv
// Load/store adapter: turns one core byte/half/word access into a word-aligned RAM
// transaction with lane-replicated store data, and extends returned load lanes.
module lsu_mem_adapter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic [31:0] ram_addr_out,
  output logic [31:0] ram_write_data_out,
  output logic        ram_read_en_out,
  output logic        ram_write_en_out,
  output logic [3:0]  ram_write_byte_en_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        rdata_valid_in,
  input  logic [31:0] ram_read_data_in
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_e;

  state_e      state_q;
  logic [1:0]  off_q, size_q;
  logic        uns_q, write_q;
  logic [31:0] cnt_q;
  logic        valid_q, rd_en_q, wr_en_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        illegal_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] lane_w;
  logic [31:0] load_data_d;
  logic        timeout_hit;

  always_comb begin
    illegal_d = (req_size_in == 2'b11) ||
                (req_size_in == 2'b01 && req_addr_in[0]) ||
                (req_size_in == 2'b10 && req_addr_in[1:0] != 2'b00);
    be_d    = 4'b0000;
    wdata_d = req_wdata_in;
    case (req_size_in)
      2'b00: begin
        be_d    = 4'b0001 << req_addr_in[1:0];
        wdata_d = {4{req_wdata_in[7:0]}};
      end
      2'b01: begin
        be_d    = req_addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata_in[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata_in;
      end
    endcase
  end

  // Addressed lane shifted down to bit 0, then zero/sign extended.
  always_comb begin
    lane_w = ram_read_data_in >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data_d = {{24{~uns_q & lane_w[7]}}, lane_w[7:0]};
      2'b01:   load_data_d = {{16{~uns_q & lane_w[15]}}, lane_w[15:0]};
      default: load_data_d = lane_w;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      cnt_q        <= 32'd0;
      valid_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      be_q         <= 4'b0000;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_in) begin
            off_q   <= req_addr_in[1:0];
            size_q  <= req_size_in;
            uns_q   <= req_unsigned_in;
            write_q <= req_write_in;
            cnt_q   <= 32'd0;
            if (illegal_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q <= REQ;
              valid_q <= 1'b1;
              rd_en_q <= ~req_write_in;
              wr_en_q <= req_write_in;
              be_q    <= req_write_in ? be_d : 4'b0000;
              addr_q  <= {req_addr_in[31:2], 2'b00};
              wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 32'd1;
          if (ready_in) begin
            valid_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            be_q    <= 4'b0000;
            if (write_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'd0;
            end else if (rdata_valid_in) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= load_data_d;
            end else begin
              state_q <= WAIT_RD;
            end
          end else if (timeout_hit) begin
            valid_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            be_q         <= 4'b0000;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end
        end
        WAIT_RD: begin
          cnt_q <= cnt_q + 32'd1;
          if (rdata_valid_in) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data_d;
          end else if (timeout_hit) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
      endcase
    end
  end

  // Held low while reset is asserted so the core cannot launch into a clearing adapter.
  assign req_ready_out         = (state_q == IDLE) && !rst;
  assign resp_valid_out        = resp_valid_q;
  assign resp_rdata_out        = resp_rdata_q;
  assign resp_err_out          = resp_err_q;
  assign ram_addr_out          = addr_q;
  assign ram_write_data_out    = wdata_q;
  assign ram_read_en_out       = rd_en_q;
  assign ram_write_en_out      = wr_en_q;
  assign ram_write_byte_en_out = be_q;
  assign valid_out             = valid_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter: vector table of loads/stores plus
// hand-written timeout and reset-abort sequences.
module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_in, req_ready_out, req_write_in, req_unsigned_in;
  logic [31:0] req_addr_in, req_wdata_in;
  logic [1:0]  req_size_in;
  logic        resp_valid_out, resp_err_out;
  logic [31:0] resp_rdata_out, ram_addr_out, ram_write_data_out;
  logic        ram_read_en_out, ram_write_en_out, valid_out;
  logic [3:0]  ram_write_byte_en_out;
  logic        ready_in, rdata_valid_in;
  logic [31:0] ram_read_data_in;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_write_in(req_write_in), .req_addr_in(req_addr_in),
    .req_wdata_in(req_wdata_in), .req_size_in(req_size_in),
    .req_unsigned_in(req_unsigned_in),
    .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out),
    .resp_err_out(resp_err_out),
    .ram_addr_out(ram_addr_out), .ram_write_data_out(ram_write_data_out),
    .ram_read_en_out(ram_read_en_out), .ram_write_en_out(ram_write_en_out),
    .ram_write_byte_en_out(ram_write_byte_en_out), .valid_out(valid_out),
    .ready_in(ready_in), .rdata_valid_in(rdata_valid_in),
    .ram_read_data_in(ram_read_data_in)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] word;
    int          dly;
    logic        ill;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    req_write_in    = v.wr;
    req_addr_in     = v.addr;
    req_wdata_in    = v.wdata;
    req_size_in     = v.size;
    req_unsigned_in = v.uns;
    req_valid_in    = 1'b1;
    chk("req_ready_idle", 32'(req_ready_out), 32'd1);
    step();
    req_valid_in = 1'b0;
    if (v.ill) begin
      chk("ill_valid_out", 32'(valid_out), 32'd0);
      chk("ill_resp_valid", 32'(resp_valid_out), 32'd1);
      chk("ill_err", 32'(resp_err_out), 32'd1);
      chk("ill_rdata", resp_rdata_out, 32'd0);
      step();
      chk("ill_resp_pulse", 32'(resp_valid_out), 32'd0);
      chk("ill_valid_after", 32'(valid_out), 32'd0);
      chk("ill_ready_back", 32'(req_ready_out), 32'd1);
      return;
    end
    chk("valid_out", 32'(valid_out), 32'd1);
    chk("ram_addr", ram_addr_out, v.e_addr);
    chk("rd_en", 32'(ram_read_en_out), 32'(!v.wr));
    chk("wr_en", 32'(ram_write_en_out), 32'(v.wr));
    chk("byte_en", 32'(ram_write_byte_en_out), 32'(v.e_be));
    if (v.wr) chk("wdata", ram_write_data_out, v.e_wdata);
    chk("req_ready_busy", 32'(req_ready_out), 32'd0);
    // RAM stalls one cycle; request must stay put
    step();
    chk("valid_held", 32'(valid_out), 32'd1);
    chk("addr_held", ram_addr_out, v.e_addr);
    chk("resp_early", 32'(resp_valid_out), 32'd0);
    ready_in = 1'b1;
    if (!v.wr && v.dly == 0) begin
      rdata_valid_in   = 1'b1;
      ram_read_data_in = v.word;
    end
    step();
    ready_in         = 1'b0;
    rdata_valid_in   = 1'b0;
    ram_read_data_in = 32'hDEADBEEF;
    chk("valid_dropped", 32'(valid_out), 32'd0);
    chk("en_dropped", 32'({ram_read_en_out, ram_write_en_out}), 32'd0);
    if (!v.wr && v.dly > 0) begin
      for (int i = 1; i < v.dly; i++) begin
        chk("resp_wait", 32'(resp_valid_out), 32'd0);
        step();
      end
      chk("resp_wait", 32'(resp_valid_out), 32'd0);
      rdata_valid_in   = 1'b1;
      ram_read_data_in = v.word;
      step();
      rdata_valid_in   = 1'b0;
      ram_read_data_in = 32'hDEADBEEF;
    end
    chk("resp_valid", 32'(resp_valid_out), 32'd1);
    chk("resp_err", 32'(resp_err_out), 32'd0);
    chk("resp_rdata", resp_rdata_out, v.e_rdata);
    step();
    chk("resp_pulse", 32'(resp_valid_out), 32'd0);
    chk("ready_back", 32'(req_ready_out), 32'd1);
  endtask

  initial begin
    //                wr    addr          wdata         sz     uns   word          dly ill   e_addr        e_wdata       e_be     e_rdata
    vecs[0]  = '{1'b1, 32'h08, 32'hFFFF0000, 2'b10, 1'b0, 32'h0,        0, 1'b0, 32'h08, 32'hFFFF0000, 4'b1111, 32'h0};
    vecs[1]  = '{1'b1, 32'h0B, 32'h000000A5, 2'b00, 1'b0, 32'h0,        0, 1'b0, 32'h08, 32'hA5A5A5A5, 4'b1000, 32'h0};
    vecs[2]  = '{1'b1, 32'h0E, 32'hABCD1234, 2'b01, 1'b0, 32'h0,        0, 1'b0, 32'h0C, 32'h12341234, 4'b1100, 32'h0};
    vecs[3]  = '{1'b0, 32'h0A, 32'h0,        2'b01, 1'b0, 32'h8001F0AB, 2, 1'b0, 32'h08, 32'h0,        4'b0000, 32'hFFFF8001};
    vecs[4]  = '{1'b0, 32'h0A, 32'h0,        2'b01, 1'b1, 32'h8001F0AB, 2, 1'b0, 32'h08, 32'h0,        4'b0000, 32'h00008001};
    vecs[5]  = '{1'b0, 32'h08, 32'h0,        2'b00, 1'b0, 32'h8001F0AB, 2, 1'b0, 32'h08, 32'h0,        4'b0000, 32'hFFFFFFAB};
    vecs[6]  = '{1'b0, 32'h09, 32'h0,        2'b00, 1'b1, 32'h8001F0AB, 0, 1'b0, 32'h08, 32'h0,        4'b0000, 32'h000000F0};
    vecs[7]  = '{1'b0, 32'h09, 32'h0,        2'b00, 1'b0, 32'h8001F0AB, 1, 1'b0, 32'h08, 32'h0,        4'b0000, 32'hFFFFFFF0};
    vecs[8]  = '{1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h8001F0AB, 0, 1'b0, 32'h10, 32'h0,        4'b0000, 32'h8001F0AB};
    vecs[9]  = '{1'b0, 32'h0B, 32'h0,        2'b00, 1'b0, 32'h8001F0AB, 1, 1'b0, 32'h08, 32'h0,        4'b0000, 32'hFFFFFF80};
    vecs[10] = '{1'b0, 32'h06, 32'h0,        2'b10, 1'b0, 32'h0,        0, 1'b1, 32'h0,  32'h0,        4'b0000, 32'h0};
    vecs[11] = '{1'b1, 32'h09, 32'h00001234, 2'b01, 1'b0, 32'h0,        0, 1'b1, 32'h0,  32'h0,        4'b0000, 32'h0};
    vecs[12] = '{1'b0, 32'h00, 32'h0,        2'b11, 1'b0, 32'h0,        0, 1'b1, 32'h0,  32'h0,        4'b0000, 32'h0};

    rst = 1'b1;
    req_valid_in = 1'b0; req_write_in = 1'b0; req_addr_in = '0; req_wdata_in = '0;
    req_size_in = 2'b00; req_unsigned_in = 1'b0;
    ready_in = 1'b0; rdata_valid_in = 1'b0; ram_read_data_in = 32'hDEADBEEF;
    step(); step();
    chk("rst_req_ready", 32'(req_ready_out), 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_resp", 32'({resp_valid_out, resp_err_out}), 32'd0);
    chk("rst_addr", ram_addr_out, 32'd0);
    chk("rst_be", 32'(ram_write_byte_en_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready_out), 32'd1);
    step();

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Timeout: store whose RAM never accepts
    req_write_in = 1'b1; req_addr_in = 32'h20; req_wdata_in = 32'h11223344;
    req_size_in = 2'b10; req_unsigned_in = 1'b0; req_valid_in = 1'b1;
    step();
    req_valid_in = 1'b0;
    chk("to_valid_rise", 32'(valid_out), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("to_valid_held", 32'(valid_out), 32'd1);
      chk("to_no_resp", 32'(resp_valid_out), 32'd0);
    end
    step();
    chk("to_valid_drop", 32'(valid_out), 32'd0);
    chk("to_resp", 32'(resp_valid_out), 32'd1);
    chk("to_err", 32'(resp_err_out), 32'd1);
    chk("to_rdata", resp_rdata_out, 32'd0);
    step();
    chk("to_resp_pulse", 32'(resp_valid_out), 32'd0);
    run_vec(vecs[0]);

    // Stray RAM handshakes while idle are ignored
    ready_in = 1'b1; rdata_valid_in = 1'b1;
    step();
    chk("idle_stray", 32'({resp_valid_out, valid_out}), 32'd0);
    ready_in = 1'b0; rdata_valid_in = 1'b0;

    // Reset while waiting for read data
    req_write_in = 1'b0; req_addr_in = 32'h08; req_size_in = 2'b00; req_valid_in = 1'b1;
    step();
    req_valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    chk("wr_in_wait", 32'(valid_out), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_resp", 32'(resp_valid_out), 32'd0);
    chk("rstw_ready", 32'(req_ready_out), 32'd0);
    #3 rst = 1'b0;
    step();
    rdata_valid_in = 1'b1; ram_read_data_in = 32'h8001F0AB;
    step();
    chk("rstw_stray_resp", 32'(resp_valid_out), 32'd0);
    step();
    chk("rstw_stray_resp2", 32'(resp_valid_out), 32'd0);
    chk("rstw_ready_back", 32'(req_ready_out), 32'd1);
    rdata_valid_in = 1'b0;

    // Reset while the RAM request is pending: valid_out drops without an edge
    req_write_in = 1'b1; req_addr_in = 32'h08; req_size_in = 2'b10; req_valid_in = 1'b1;
    step();
    req_valid_in = 1'b0;
    chk("rstr_valid_before", 32'(valid_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstr_valid_drop", 32'(valid_out), 32'd0);
    chk("rstr_wr_en_drop", 32'(ram_write_en_out), 32'd0);
    #3 rst = 1'b0;
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    chk("rstr_no_resp", 32'(resp_valid_out), 32'd0);
    run_vec(vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
